// File: rtl/fp_alu_scheduler.sv
// Single-issue scheduler for external add/mul/div FP units: NaN and divide-by-zero
// requests are answered directly; other requests are launched, timed and captured.
module fp_alu_scheduler #(
  parameter int LAT_ADD = 2,
  parameter int LAT_MUL = 2,
  parameter int LAT_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [1:0]  u_sel,
  output logic [31:0] u_a,
  output logic [31:0] u_b,
  output logic        u_start,
  input  logic [31:0] u_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_flags,
  output logic        busy
);

  localparam int CW = 8;
  localparam logic [CW-1:0] LOAD_ADD = CW'(LAT_ADD - 1);
  localparam logic [CW-1:0] LOAD_MUL = CW'(LAT_MUL - 1);
  localparam logic [CW-1:0] LOAD_DIV = CW'(LAT_DIV - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          u_start_q, u_start_d;
  logic [1:0]    u_sel_q, u_sel_d;
  logic [31:0]   u_a_q, u_a_d;
  logic [31:0]   u_b_q, u_b_d;
  logic [31:0]   rsp_result_q, rsp_result_d;
  logic [2:0]    rsp_flags_q, rsp_flags_d;
  logic          op_nan, op_dz;

  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (&x[30:23]) && !(|x[22:0]);
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    u_start_d    = 1'b0;
    u_sel_d      = u_sel_q;
    u_a_d        = u_a_q;
    u_b_d        = u_b_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    op_nan       = is_nan(req_a) || is_nan(req_b);
    op_dz        = (req_op == 2'b11) && (req_b[30:0] == 31'd0);

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (op_nan) begin
            rsp_result_d = 32'h7FC0_0000;
            rsp_flags_d  = 3'b100;
            state_d      = RESP;
          end else if (op_dz) begin
            rsp_result_d = {req_a[31] ^ req_b[31], 8'hFF, 23'd0};
            rsp_flags_d  = 3'b011;
            state_d      = RESP;
          end else begin
            // Subtraction runs on the add unit with the sign of B flipped.
            u_sel_d   = (req_op == 2'b01) ? 2'b00 : req_op;
            u_a_d     = req_a;
            u_b_d     = (req_op == 2'b01) ? {~req_b[31], req_b[30:0]} : req_b;
            u_start_d = 1'b1;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        case (u_sel_q)
          2'b11:   cnt_d = LOAD_DIV;
          2'b10:   cnt_d = LOAD_MUL;
          default: cnt_d = LOAD_ADD;
        endcase
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_result_d = u_result;
          rsp_flags_d  = {is_nan(u_result), is_inf(u_result), 1'b0};
          u_sel_d      = 2'b00;
          u_a_d        = 32'd0;
          u_b_d        = 32'd0;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      u_start_q    <= 1'b0;
      u_sel_q      <= 2'b00;
      u_a_q        <= 32'd0;
      u_b_q        <= 32'd0;
      rsp_result_q <= 32'd0;
      rsp_flags_q  <= 3'b000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      u_start_q    <= u_start_d;
      u_sel_q      <= u_sel_d;
      u_a_q        <= u_a_d;
      u_b_q        <= u_b_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  // req_ready is gated by rst so nothing is offered while reset is held.
  assign req_ready  = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign u_start    = u_start_q;
  assign u_sel      = u_sel_q;
  assign u_a        = u_a_q;
  assign u_b        = u_b_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_fp_alu_scheduler.sv
// Bench for fp_alu_scheduler: behavioural FP unit with fixed latency plus a
// scoreboard of expected responses pushed at issue and popped at response.
module tb_fp_alu_scheduler;
  localparam int LAT_ADD = 2;
  localparam int LAT_MUL = 2;
  localparam int LAT_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [1:0]  u_sel;
  logic [31:0] u_a, u_b;
  logic        u_start;
  logic [31:0] u_result = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [2:0]  rsp_flags;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  flags;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] unit_ans = 32'd0;
  logic [31:0] unit_pend = 32'd0;
  int          unit_rem = 0;

  fp_alu_scheduler #(.LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .u_sel(u_sel), .u_a(u_a),
    .u_b(u_b), .u_start(u_start), .u_result(u_result), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  // Unit model: result becomes valid LAT edges after the edge that samples u_start.
  always @(negedge clk) begin
    if (u_start === 1'b1) begin
      unit_rem  = (u_sel == 2'b11) ? LAT_DIV : (u_sel == 2'b10) ? LAT_MUL : LAT_ADD;
      unit_pend = unit_ans;
      u_result  = 32'h1234_5678;
    end else if (unit_rem > 0) begin
      unit_rem--;
      if (unit_rem == 0) u_result = unit_pend;
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ans, input logic [31:0] exp_res,
                        input logic [2:0] exp_flags, input int exp_lat, input bit bypass,
                        input logic [1:0] exp_sel, input logic [31:0] exp_ub, input int hold);
    exp_t e, got;
    int lat, starts;
    bit done;
    sb_q.push_back({exp_res, exp_flags});
    unit_ans = ans;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL %s_ready got %b want 1", name, req_ready); end
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = ~op; req_a = 32'hDEAD_BEEF; req_b = 32'hDEAD_BEEF;
    lat = 1; starts = 0; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (u_start === 1'b1) begin
        starts++;
        checks++;
        if (u_sel !== exp_sel || u_a !== a || u_b !== exp_ub) begin
          fails++;
          $display("FAIL %s_launch got sel=%b a=%h b=%h want sel=%b a=%h b=%h",
                   name, u_sel, u_a, u_b, exp_sel, a, exp_ub);
        end
      end else if (rsp_valid !== 1'b1 && !bypass) begin
        checks++;
        if (u_sel !== exp_sel || u_b !== exp_ub) begin
          fails++;
          $display("FAIL %s_hold got sel=%b b=%h want sel=%b b=%h", name, u_sel, u_b, exp_sel, exp_ub);
        end
      end
      if (rsp_valid === 1'b1) done = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
    checks++;
    if (!done) begin fails++; $display("FAIL %s_timeout got no rsp_valid want rsp_valid", name); end
    checks++;
    if (lat != exp_lat) begin fails++; $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat); end
    checks++;
    if (starts != (bypass ? 0 : 1)) begin
      fails++; $display("FAIL %s_starts got %0d want %0d", name, starts, bypass ? 0 : 1);
    end
    checks++;
    if (u_sel !== 2'b00 || u_a !== 32'd0 || u_b !== 32'd0 || busy !== 1'b1) begin
      fails++; $display("FAIL %s_resp_idle_unit got sel=%b a=%h b=%h busy=%b want 0 0 0 1", name, u_sel, u_a, u_b, busy);
    end
    got = {rsp_result, rsp_flags};
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || {rsp_result, rsp_flags} !== got || req_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s_backpressure got valid=%b res=%h ready=%b want valid=1 res=%h ready=0",
                 name, rsp_valid, rsp_result, req_ready, got.res);
      end
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL %s_release got busy=%b valid=%b ready=%b want 0 0 1", name, busy, rsp_valid, req_ready);
    end
    e = sb_q.pop_front();
    checks++;
    if (got !== e) begin
      fails++; $display("FAIL %s_result got %h/%b want %h/%b", name, got.res, got.flags, e.res, e.flags);
    end
    $display("%s: op=%b a=%h b=%h result=%h flags=%b latency=%0d", name, op, a, b, got.res, got.flags, lat);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (u_start !== 1'b0 || u_sel !== 2'b00 || u_a !== 32'd0 || u_b !== 32'd0 || rsp_valid !== 1'b0 ||
        rsp_result !== 32'd0 || rsp_flags !== 3'b000 || busy !== 1'b0 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL %s got start=%b sel=%b a=%h b=%h valid=%b res=%h flags=%b busy=%b ready=%b want all 0",
               name, u_start, u_sel, u_a, u_b, rsp_valid, rsp_result, rsp_flags, busy, req_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    check_all_zero("reset_async");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_release got ready=%b busy=%b want 1 0", req_ready, busy);
    end
    $display("reset: ready=%b busy=%b", req_ready, busy);
  endtask

  task automatic test_div();
    run_op("div", 2'b11, 32'hC070_0000, 32'h3FC0_0000, 32'hC020_0000, 32'hC020_0000, 3'b000,
           LAT_DIV + 2, 1'b0, 2'b11, 32'h3FC0_0000, 0);
  endtask

  task automatic test_add_sub();
    run_op("sub", 2'b01, 32'h4090_0000, 32'h3F40_0000, 32'h4070_0000, 32'h4070_0000, 3'b000,
           LAT_ADD + 2, 1'b0, 2'b00, 32'hBF40_0000, 0);
    run_op("add", 2'b00, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4040_0000, 3'b000,
           LAT_ADD + 2, 1'b0, 2'b00, 32'h4000_0000, 0);
  endtask

  task automatic test_result_flags();
    run_op("mul_inf", 2'b10, 32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 32'h7F80_0000, 3'b010,
           LAT_MUL + 2, 1'b0, 2'b10, 32'h4000_0000, 0);
    run_op("mul_nan", 2'b10, 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7FC0_0000, 3'b100,
           LAT_MUL + 2, 1'b0, 2'b10, 32'h0000_0000, 0);
  endtask

  task automatic test_bypass();
    run_op("div_zero", 2'b11, 32'h4090_0000, 32'h8000_0000, 32'h0, 32'hFF80_0000, 3'b011,
           1, 1'b1, 2'b00, 32'h0, 0);
    run_op("nan_in", 2'b00, 32'h7FC0_0001, 32'h3F80_0000, 32'h0, 32'h7FC0_0000, 3'b100,
           1, 1'b1, 2'b00, 32'h0, 0);
    run_op("nan_over_dz", 2'b11, 32'h7FC0_0001, 32'h0000_0000, 32'h0, 32'h7FC0_0000, 3'b100,
           1, 1'b1, 2'b00, 32'h0, 0);
  endtask

  task automatic test_backpressure();
    run_op("div_bp", 2'b11, 32'h42C8_0000, 32'h41C8_0000, 32'h4080_0000, 32'h4080_0000, 3'b000,
           LAT_DIV + 2, 1'b0, 2'b11, 32'h41C8_0000, 5);
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    int responses = 0;
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 1'b1; req_op = 2'b10; req_a = 32'h7FC0_0001; req_b = 32'h0;
    for (int i = 0; i < 6; i++) begin
      if (req_ready === 1'b1) accepted++;
      if (rsp_valid === 1'b1) begin
        responses++;
        checks++;
        if (rsp_result !== 32'h7FC0_0000) begin
          fails++; $display("FAIL b2b_result got %h want 7fc00000", rsp_result);
        end
      end
      @(posedge clk); @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    checks++;
    if (accepted != 3 || responses != 3) begin
      fails++; $display("FAIL b2b_spacing got acc=%0d rsp=%0d want 3 3", accepted, responses);
    end
    $display("back_to_back: accepted=%0d responses=%0d", accepted, responses);
  endtask

  task automatic test_reset_mid_wait();
    int stray = 0;
    unit_ans = 32'h4000_0000;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_a = 32'h4080_0000; req_b = 32'h4000_0000;
    @(posedge clk); #1; req_valid = 1'b0;
    checks++;
    if (u_start !== 1'b1) begin fails++; $display("FAIL rmw_start got %b want 1", u_start); end
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_all_zero("rmw_async");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin fails++; $display("FAIL rmw_no_pulse got %0d stray cycles want 0", stray); end
    $display("reset_mid_wait: stray=%0d", stray);
    run_op("div_after_rst", 2'b11, 32'hC070_0000, 32'h3FC0_0000, 32'hC020_0000, 32'hC020_0000, 3'b000,
           LAT_DIV + 2, 1'b0, 2'b11, 32'h3FC0_0000, 0);
  endtask

  initial begin
    test_reset();
    test_div();
    test_add_sub();
    test_result_flags();
    test_bypass();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wait();
    checks++;
    if (sb_q.size() != 0) begin fails++; $display("FAIL scoreboard_left got %0d want 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
